phase_diff_arbiter: RTL

- Shares one diff_phase differentiator (latency 3) between two AIS receive channels (A/B) by time-multiplexing their phase streams.
- Keeps a per-channel last-phase context. For each new sample it issues two beats to the shared differentiator:
  - a prime beat carrying the channel's stored previous phase;
  - a data beat carrying the new phase.
- Drops the prime-beat result and routes the data-beat result to the owning channel's output.
- Sits between the per-channel phase extractors and the per-channel frame detectors.

---
 rtl/phase_diff_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/phase_diff_arbiter.sv
// Time-multiplexes two phase streams onto one shared diff_phase differentiator.
// Each sample issues a prime beat (stored context) then a data beat; only data-beat results are routed out.
module phase_diff_arbiter #(
  parameter int PAR_PHASE_WIDTH = 16,
  parameter int PAR_TAG_DEPTH   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       s0_axis_tvalid,
  output logic                       s0_axis_tready,
  input  logic [PAR_PHASE_WIDTH-1:0] s0_axis_tdata,
  input  logic                       s1_axis_tvalid,
  output logic                       s1_axis_tready,
  input  logic [PAR_PHASE_WIDTH-1:0] s1_axis_tdata,
  input  logic [1:0]                 i_ch_clr,
  output logic                       m_dp_tvalid,
  output logic [PAR_PHASE_WIDTH-1:0] m_dp_tdata,
  input  logic                       s_dp_tvalid,
  input  logic [PAR_PHASE_WIDTH-1:0] s_dp_tdata,
  output logic                       m0_axis_tvalid,
  output logic [PAR_PHASE_WIDTH-1:0] m0_axis_tdata,
  output logic                       m1_axis_tvalid,
  output logic [PAR_PHASE_WIDTH-1:0] m1_axis_tdata,
  output logic                       o_err
);

  localparam int PW = PAR_PHASE_WIDTH;
  localparam int AW = (PAR_TAG_DEPTH > 1) ? $clog2(PAR_TAG_DEPTH) : 1;
  localparam int CW = $clog2(PAR_TAG_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_DATA} state_t;
  typedef struct packed {
    logic keep;
    logic ch;
  } tag_t;

  state_t             state_q, state_d;
  logic               cur_ch_q, cur_ch_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         hold_full_q, hold_full_d;
  logic [1:0]         primed_q, primed_d;
  logic [1:0][PW-1:0] hold_q, hold_d;
  logic [1:0][PW-1:0] ctx_q, ctx_d;
  logic               dp_valid_q, dp_valid_d;
  logic [PW-1:0]      dp_data_q, dp_data_d;
  logic [1:0]         m_valid_q, m_valid_d;
  logic [1:0][PW-1:0] m_data_q, m_data_d;
  logic               err_q, err_d;

  tag_t               tag_mem [PAR_TAG_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [1:0]         s_valid;
  logic [1:0][PW-1:0] s_data;
  logic               winner;
  logic               issue_data;
  logic               push, pop, do_push, do_pop;
  logic               fifo_full, fifo_empty;
  tag_t               push_tag, head;

  assign s_valid = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_data  = {s1_axis_tdata, s0_axis_tdata};

  // Round-robin: on a tie the channel that did not win last time goes next.
  assign winner     = hold_full_q[1] & (~hold_full_q[0] | ~last_grant_q);
  assign issue_data = (state_q == ST_PRIME);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(PAR_TAG_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    dp_valid_d   = 1'b0;
    dp_data_d    = dp_data_q;
    push         = 1'b0;
    push_tag     = '0;
    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (|hold_full_q) begin
          state_d      = ST_PRIME;
          cur_ch_d     = winner;
          last_grant_d = winner;
          dp_valid_d   = 1'b1;
          dp_data_d    = ctx_q[winner];
          push         = 1'b1;
          push_tag     = '{keep: 1'b0, ch: winner};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        state_d    = ST_DATA;
        dp_valid_d = 1'b1;
        dp_data_d  = hold_q[cur_ch_q];
        push       = 1'b1;
        push_tag   = '{keep: primed_q[cur_ch_q], ch: cur_ch_q};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ctx_d       = ctx_q;
    primed_d    = primed_q;
    for (int n = 0; n < 2; n++) begin
      if (issue_data && (cur_ch_q == 1'(n))) begin
        ctx_d[n]       = hold_q[n];
        primed_d[n]    = 1'b1;
        hold_full_d[n] = 1'b0;
      end
      if (s_valid[n] && !hold_full_q[n]) begin
        hold_d[n]      = s_data[n];
        hold_full_d[n] = 1'b1;
      end
      // A clear overrides both capture and the data-beat context update.
      if (i_ch_clr[n]) begin
        ctx_d[n]       = '0;
        primed_d[n]    = 1'b0;
        hold_full_d[n] = 1'b0;
      end
    end
  end

  assign pop        = s_dp_tvalid;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(PAR_TAG_DEPTH));
  assign do_push    = push & (~fifo_full | pop);
  assign do_pop     = pop & ~fifo_empty;
  assign head       = tag_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q + CW'(do_push) - CW'(do_pop);
    err_d     = err_q | (push & fifo_full & ~pop) | (pop & fifo_empty);
    m_valid_d = '0;
    m_data_d  = m_data_q;
    if (pop && head.keep) begin
      m_valid_d[head.ch] = 1'b1;
      m_data_d[head.ch]  = s_dp_tdata;
    end
  end

  // NOTE: the tag storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) tag_mem[wr_ptr_q] <= push_tag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cur_ch_q     <= 1'b0;
      last_grant_q <= 1'b1;
      hold_full_q  <= '0;
      primed_q     <= '0;
      hold_q       <= '0;
      ctx_q        <= '0;
      dp_valid_q   <= 1'b0;
      dp_data_q    <= '0;
      m_valid_q    <= '0;
      m_data_q     <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      hold_full_q  <= hold_full_d;
      primed_q     <= primed_d;
      hold_q       <= hold_d;
      ctx_q        <= ctx_d;
      dp_valid_q   <= dp_valid_d;
      dp_data_q    <= dp_data_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign s0_axis_tready = ~hold_full_q[0];
  assign s1_axis_tready = ~hold_full_q[1];
  assign m_dp_tvalid    = dp_valid_q;
  assign m_dp_tdata     = dp_data_q;
  assign m0_axis_tvalid = m_valid_q[0];
  assign m0_axis_tdata  = m_data_q[0];
  assign m1_axis_tvalid = m_valid_q[1];
  assign m1_axis_tdata  = m_data_q[1];
  assign o_err          = err_q;

endmodule
